// File: rtl/pll_pi_loop_filter.sv
// rtl/pll_pi_loop_filter.sv - PI loop filter: bang-bang PD in, saturating DCO control word out
module pll_pi_loop_filter #(
    parameter int                 ACC_W      = 32,
    parameter int                 OUT_W      = 16,
    parameter logic signed [15:0] KP_ACQ     = 16'sd7,
    parameter logic signed [15:0] KI_ACQ     = 16'sd4,
    parameter logic signed [15:0] KP_TRK     = 16'sd2,
    parameter logic signed [15:0] KI_TRK     = 16'sd1,
    parameter int                 LOCK_CNT   = 8,
    parameter int                 UNLOCK_CNT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    up,
    input  logic                    down,
    input  logic                    freeze,
    output logic signed [OUT_W-1:0] filtered_control_signal,
    output logic                    locked,
    output logic                    acc_sat,
    input  logic                    scan_in,
    input  logic                    scan_en,
    output logic                    scan_out
);
    localparam int EXT_W   = ACC_W + 17;
    localparam int CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_TGT   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] UNLOCK_TGT = CNT_W'(UNLOCK_CNT);
    localparam logic signed [EXT_W-1:0] ACC_MAX = {{18{1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] ACC_MIN = {{18{1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [EXT_W-1:0] OUT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] OUT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic {MODE_ACQ = 1'b0, MODE_TRK = 1'b1} mode_t;

    logic signed [ACC_W-1:0] acc_q, acc_next;
    logic signed [OUT_W-1:0] out_q, out_next;
    mode_t                   mode_q, mode_d;
    logic [CNT_W-1:0]        alt_q, alt_d, run_q, run_d, alt_inc, run_inc;
    logic                    last_neg_q, last_neg_d, last_valid_q, last_valid_d;
    logic                    sat_q, acc_clamp;
    logic                    err_nz, err_neg;
    logic signed [15:0]      kp_sel, ki_sel;
    logic signed [EXT_W-1:0] acc_ext, kp_ext, ki_ext, kp_term, ki_term, acc_sum, out_sum;

    assign err_nz  = up ^ down;
    assign err_neg = up & ~down;
    assign kp_sel  = (mode_q == MODE_TRK) ? KP_TRK : KP_ACQ;
    assign ki_sel  = (mode_q == MODE_TRK) ? KI_TRK : KI_ACQ;

    assign acc_ext = {{17{acc_q[ACC_W-1]}}, acc_q};
    assign kp_ext  = {{(ACC_W+1){kp_sel[15]}}, kp_sel};
    assign ki_ext  = {{(ACC_W+1){ki_sel[15]}}, ki_sel};
    assign kp_term = err_nz ? (err_neg ? -kp_ext : kp_ext) : '0;
    assign ki_term = err_nz ? (err_neg ? -ki_ext : ki_ext) : '0;
    assign acc_sum = acc_ext + ki_term;
    assign out_sum = acc_ext + kp_term;

    // Sums are wide enough never to overflow, so clamping is a plain compare.
    always_comb begin
        acc_clamp = 1'b1;
        acc_next  = acc_sum[ACC_W-1:0];
        if (acc_sum > ACC_MAX)      acc_next = ACC_MAX[ACC_W-1:0];
        else if (acc_sum < ACC_MIN) acc_next = ACC_MIN[ACC_W-1:0];
        else                        acc_clamp = 1'b0;

        out_next = out_sum[OUT_W-1:0];
        if (out_sum > OUT_MAX)      out_next = OUT_MAX[OUT_W-1:0];
        else if (out_sum < OUT_MIN) out_next = OUT_MIN[OUT_W-1:0];
    end

    assign alt_inc = alt_q + 1'b1;
    assign run_inc = run_q + 1'b1;

    always_comb begin
        mode_d       = mode_q;
        alt_d        = alt_q;
        run_d        = run_q;
        last_neg_d   = last_neg_q;
        last_valid_d = last_valid_q;
        if (err_nz) begin
            last_neg_d   = err_neg;
            last_valid_d = 1'b1;
            if (!last_valid_q) begin
                alt_d = '0;
                run_d = CNT_W'(1);
            end else if (mode_q == MODE_ACQ) begin
                if (err_neg != last_neg_q) alt_d = alt_inc;
                else                       alt_d = '0;
                if (err_neg != last_neg_q && alt_inc == LOCK_TGT) begin
                    mode_d       = MODE_TRK;
                    alt_d        = '0;
                    run_d        = '0;
                    last_valid_d = 1'b0;
                end
            end else begin
                if (err_neg == last_neg_q) run_d = run_inc;
                else                       run_d = CNT_W'(1);
                if (err_neg == last_neg_q && run_inc == UNLOCK_TGT) begin
                    mode_d       = MODE_ACQ;
                    alt_d        = '0;
                    run_d        = '0;
                    last_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            mode_q       <= MODE_ACQ;
            alt_q        <= '0;
            run_q        <= '0;
            last_neg_q   <= 1'b0;
            last_valid_q <= 1'b0;
            out_q        <= '0;
            sat_q        <= 1'b0;
        end else if (scan_en) begin
            acc_q  <= {acc_q[ACC_W-2:0], scan_in};
            mode_q <= mode_t'(acc_q[ACC_W-1]);
        end else if (freeze) begin
            out_q <= out_next;
            sat_q <= 1'b0;
        end else begin
            acc_q        <= acc_next;
            mode_q       <= mode_d;
            alt_q        <= alt_d;
            run_q        <= run_d;
            last_neg_q   <= last_neg_d;
            last_valid_q <= last_valid_d;
            out_q        <= out_next;
            sat_q        <= acc_clamp;
        end
    end

    assign filtered_control_signal = out_q;
    assign locked                  = (mode_q == MODE_TRK);
    assign acc_sat                 = sat_q;
    assign scan_out                = locked;
endmodule

// File: tb/tb_pll_pi_loop_filter.sv
// tb/tb_pll_pi_loop_filter.sv - self-checking bench for pll_pi_loop_filter (default and 8-bit builds)
module tb_pll_pi_loop_filter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, up, down, freeze, scan_in, scan_en;
    logic signed [15:0] out_a;
    logic signed [7:0]  out_b;
    logic locked_a, sat_a, so_a, locked_b, sat_b, so_b;

    pll_pi_loop_filter dut_a (
        .clk(clk), .rst(rst), .up(up), .down(down), .freeze(freeze),
        .filtered_control_signal(out_a), .locked(locked_a), .acc_sat(sat_a),
        .scan_in(scan_in), .scan_en(scan_en), .scan_out(so_a)
    );

    pll_pi_loop_filter #(.ACC_W(8), .OUT_W(8)) dut_b (
        .clk(clk), .rst(rst), .up(up), .down(down), .freeze(freeze),
        .filtered_control_signal(out_b), .locked(locked_b), .acc_sat(sat_b),
        .scan_in(scan_in), .scan_en(scan_en), .scan_out(so_b)
    );

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", name, ncyc, act, exp);
        end
    endtask

    // Reference model: integer arithmetic on the documented rules, one slot per build.
    int     aw[2] = '{32, 8};
    int     ow[2] = '{16, 8};
    longint m_acc[2], m_out[2];
    int     m_mode[2], m_ls[2], m_alt[2], m_run[2];
    bit     m_sat[2];

    function automatic longint clampw(longint v, int w);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint wrapw(longint v, int w);
        longint m;
        m = longint'(1) << w;
        v = v & (m - 1);
        if (v >= m / 2) v = v - m;
        return v;
    endfunction

    task automatic mstep(int d);
        int     e;
        longint kp, ki, nacc, mask;
        e  = (up && !down) ? -1 : ((down && !up) ? 1 : 0);
        kp = (m_mode[d] == 1) ? 2 : 7;
        ki = (m_mode[d] == 1) ? 1 : 4;
        mask = (longint'(1) << aw[d]) - 1;
        if (rst) begin
            m_acc[d] = 0; m_out[d] = 0; m_mode[d] = 0; m_ls[d] = 0;
            m_alt[d] = 0; m_run[d] = 0; m_sat[d] = 0;
        end else if (scan_en) begin
            m_mode[d] = int'(((m_acc[d] & mask) >> (aw[d] - 1)) & 1);
            m_acc[d]  = wrapw((m_acc[d] << 1) | longint'(scan_in), aw[d]);
        end else begin
            m_out[d] = clampw(m_acc[d] + kp * e, ow[d]);
            if (freeze) begin
                m_sat[d] = 0;
            end else begin
                nacc     = m_acc[d] + ki * e;
                m_acc[d] = clampw(nacc, aw[d]);
                m_sat[d] = (nacc != m_acc[d]);
                if (e != 0) begin
                    if (m_ls[d] == 0) begin
                        m_alt[d] = 0; m_run[d] = 1;
                    end else if (m_mode[d] == 0) begin
                        m_alt[d] = (e != m_ls[d]) ? m_alt[d] + 1 : 0;
                    end else begin
                        m_run[d] = (e == m_ls[d]) ? m_run[d] + 1 : 1;
                    end
                    m_ls[d] = e;
                    if ((m_mode[d] == 0 && m_alt[d] == 8) || (m_mode[d] == 1 && m_run[d] == 4)) begin
                        m_mode[d] = 1 - m_mode[d];
                        m_alt[d] = 0; m_run[d] = 0; m_ls[d] = 0;
                    end
                end
            end
        end
    endtask

    task automatic cyc(bit r, bit se, bit fr, bit u, bit dn, bit si);
        rst = r; scan_en = se; freeze = fr; up = u; down = dn; scan_in = si;
        @(posedge clk);
        mstep(0);
        mstep(1);
        ncyc++;
        @(negedge clk);
        chk("out_a",  out_a,    m_out[0]);
        chk("lock_a", locked_a, m_mode[0]);
        chk("sat_a",  sat_a,    m_sat[0]);
        chk("so_a",   so_a,     m_mode[0]);
        chk("out_b",  out_b,    m_out[1]);
        chk("lock_b", locked_b, m_mode[1]);
        chk("sat_b",  sat_b,    m_sat[1]);
        chk("so_b",   so_b,     m_mode[1]);
    endtask

    typedef struct {
        bit r, se, fr, u, dn, si;
        int exp_out;
        bit exp_lock;
        bit exp_sat;
    } vec_t;

    vec_t tbl[6];
    logic [32:0] pat;
    int pu, pd, kind;
    bit tog, r_, se_, fr_, u_, dn_, si_;

    initial begin
        rst = 1'b1; scan_en = 1'b0; freeze = 1'b0; up = 1'b0; down = 1'b0; scan_in = 1'b0;
        tbl[0] = '{1, 0, 0, 0, 0, 0,   0, 0, 0};
        tbl[1] = '{0, 0, 0, 1, 0, 0,  -7, 0, 0};
        tbl[2] = '{0, 0, 0, 1, 0, 0, -11, 0, 0};
        tbl[3] = '{0, 0, 0, 1, 0, 0, -15, 0, 0};
        tbl[4] = '{0, 0, 0, 0, 0, 0, -12, 0, 0};
        tbl[5] = '{0, 0, 0, 0, 1, 0,  -5, 0, 0};
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].r, tbl[i].se, tbl[i].fr, tbl[i].u, tbl[i].dn, tbl[i].si);
            chk("tbl_out_a",  out_a,    tbl[i].exp_out);
            chk("tbl_lock_a", locked_a, tbl[i].exp_lock);
            chk("tbl_sat_a",  sat_a,    tbl[i].exp_sat);
            chk("tbl_out_b",  out_b,    tbl[i].exp_out);
        end

        // Lock acquisition on alternating events with idle gaps.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 0, (i % 2) == 0, (i % 2) == 1, 0);
            if (i == 7) chk("lock_before_9th", locked_a, 0);
            if (i == 8) chk("lock_after_9th", locked_a, 1);
            cyc(0, 0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 1, 0);
        chk("trk_kp_out", out_a, -2);
        cyc(0, 0, 0, 0, 0, 0);
        chk("trk_ki_acc", out_a, -3);

        // A down inside the same-sign run keeps TRACK; then four ups drop lock.
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("run_broken_lock", locked_a, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, 0, 0);
            if (i == 2) chk("unlock_3rd", locked_a, 1);
            if (i == 3) chk("unlock_4th", locked_a, 0);
        end

        // 8-bit build: positive saturation without wrap, then recovery.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0, 1, 0);
        chk("sat8_out", out_b, 127);
        chk("sat8_flag", sat_b, 1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("sat8_up_out", out_b, 120);
        chk("sat8_up_flag", sat_b, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("sat8_acc", out_b, 123);

        // Scan load of mode and accumulator, MSB (mode) first.
        pat = 33'h1_A5A5_5A5A;
        for (int i = 32; i >= 0; i--) cyc(0, 1, 0, 0, 0, pat[i]);
        chk("scan_mode", locked_a, 1);
        pat = 33'h0_0000_0100;
        for (int i = 32; i >= 0; i--) cyc(0, 1, 0, 0, 0, pat[i]);
        cyc(0, 0, 0, 0, 0, 0);
        chk("scan_acc", out_a, 256);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 1, 0, 0);
            chk("freeze_out", out_a, 249);
        end
        chk("freeze_lock", locked_a, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("freeze_acc_held", out_a, 256);
        cyc(1, 1, 1, 1, 0, 1);
        chk("rst_scan_out_a", out_a, 0);
        chk("rst_scan_lock_a", locked_a, 0);
        chk("rst_scan_out_b", out_b, 0);

        // Randomized blocks against the model.
        tog = 1'b0;
        for (int blk = 0; blk < 8; blk++) begin
            kind = $urandom_range(0, 1);
            pu   = $urandom_range(0, 100);
            pd   = $urandom_range(0, 100);
            for (int i = 0; i < 100; i++) begin
                r_  = ($urandom_range(0, 149) == 0);
                se_ = ($urandom_range(0, 29) == 0);
                fr_ = ($urandom_range(0, 9) == 0);
                si_ = 1'($urandom_range(0, 1));
                if (kind == 0) begin
                    u_  = ($urandom_range(0, 99) < pu);
                    dn_ = ($urandom_range(0, 99) < pd);
                end else if ($urandom_range(0, 2) == 0) begin
                    u_ = 1'b0; dn_ = 1'b0;
                end else begin
                    u_ = tog; dn_ = ~tog; tog = ~tog;
                end
                cyc(r_, se_, fr_, u_, dn_, si_);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pll_pi_loop_filter.md
# pll_pi_loop_filter

Parametrised second-generation PI loop filter for the digital PLL: converts bang-bang phase-detector up/down pulses into a signed saturating control word for the DCO. Adds over the first-generation filter: configurable accumulator/output widths, separate acquisition and tracking gain sets with automatic lock detection, saturation on accumulator and output, a freeze input, a registered output, and a scan chain extended to cover the mode bit.

## Interface
- ACC_W, 32, integrator accumulator width (signed, ≥ OUT_W)
- OUT_W, 16, control-word width (signed)
- KP_ACQ / KI_ACQ, 7 / 4, signed 16-bit proportional / integral gains in ACQUIRE
- KP_TRK / KI_TRK, 2 / 1, signed 16-bit gains in TRACK
- LOCK_CNT, 8, consecutive sign alternations required to enter TRACK (≥1)
- UNLOCK_CNT, 4, consecutive same-sign errors that force ACQUIRE (≥2)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- up  in  1  PD "up" pulse
- down  in  1  PD "down" pulse
- freeze  in  1  hold integrator, mode and counters
- filtered_control_signal  out  OUT_W  registered signed control word
- locked  out  1  high in TRACK
- acc_sat  out  1  registered; high when the last accumulator update clamped
- scan_in  in  1  scan data in
- scan_en  in  1  scan shift enable
- scan_out  out  1  scan data out

## Operation
- Error decode: {up,down}=10 → err=-1; 01 → +1; 00 or 11 → 0.
- Gains (Kp, Ki) selected by current registered mode (ACQUIRE/TRACK).
- Priority per edge: rst > scan_en > freeze > normal.
- Reset: acc=0, mode=ACQUIRE, counters=0, last_sign invalid, filtered_control_signal=0, locked=0, acc_sat=0.
- Normal: acc ← sat_ACC(acc + Ki·err); filtered_control_signal ← sat_OUT(acc_old + Kp·err); acc_sat ← 1 iff clamping occurred.
- Arithmetic: compute sums at ACC_W+17 bits signed, then clamp to [-2^(W-1), 2^(W-1)-1] of the target width. Never wrap.
- Lock FSM, updated only on nonzero err (err=0 leaves counters and last_sign unchanged):
  - First nonzero err after reset/transition: record last_sign, alt_cnt=0, run_cnt=1.
  - ACQUIRE: sign ≠ last_sign → alt_cnt+1; equal → alt_cnt=0. When alt_cnt reaches LOCK_CNT → TRACK.
  - TRACK: sign = last_sign → run_cnt+1; else run_cnt=1. When run_cnt reaches UNLOCK_CNT → ACQUIRE.
  - On every transition, clear alt_cnt and run_cnt and invalidate last_sign.
- Freeze: acc, mode, counters and last_sign hold; output still updates as sat_OUT(acc + Kp·err); acc_sat cleared.
- Scan (scan_en=1): chain of ACC_W+1 bits: scan_in → acc[0] → … → acc[ACC_W-1] → mode → scan_out; scan_out = mode bit. Counters, last_sign, output and acc_sat hold. Lock FSM inactive.
- locked is the registered mode bit (TRACK=1).

## Timing
- err sampled at edge k; acc, mode, filtered_control_signal and acc_sat visible after edge k (one-cycle latency).
- Output at edge k uses acc and mode prior to edge k.
- Mode change takes effect for gains on the edge after the transition edge.
- rst asserted mid-operation: all state at reset values after that edge, regardless of scan_en/freeze.
- Scan chain: a bit entering scan_in appears on scan_out ACC_W+1 edges later.
- No combinational input-to-output paths.

## Test plan
- Defaults, rst then up=1 for 3 edges → output -7, -11, -15; acc -4, -8, -12; locked=0.
- Alternate up/down for 9 nonzero events (idle cycles interleaved) → locked=1 after 9th event; next down gives acc step +1, Kp term +2.
- In TRACK, 4 consecutive up events → locked=0 after 4th; a down within the run resets run_cnt and keeps TRACK.
- ACC_W=8, OUT_W=8, down held 40 edges → acc clamps at 127, acc_sat=1, output 127 without wrap; then up → acc 123, acc_sat=0.
- scan_en: shift 33-bit pattern 0x1_A5A5_5A5A in → scan_out shows prior state (acc, mode) over 33 edges; after shift, acc=0xA5A55A5A-derived value and mode loaded; output and counters held.
- freeze=1 with up held 5 edges → acc unchanged, output = acc-7 each edge; rst asserted during scan_en=1 → all outputs 0, locked=0 next edge.
